// File: rtl/kip_rx_merger.sv
// Merges local loopback and remote (GULF-Stream) AXI-Stream traffic toward the kernel switch.
// Packet-atomic round-robin arbitration feeding a registered two-entry skid buffer.
module kip_rx_merger #(
  parameter int unsigned AXIS_DATA_WIDTH      = 512,
  parameter int unsigned AXIS_KEEP_WIDTH      = AXIS_DATA_WIDTH / 8,
  parameter int unsigned AXIS_KIP_TUSER_WIDTH = 32,
  parameter int unsigned IP_ADDRESS_WIDTH     = 32,
  parameter int unsigned COUNT_WIDTH          = 32
) (
  input  logic                            i_clk,
  input  logic                            i_ap_rst_n,

  input  logic                            from_local_tvalid,
  output logic                            from_local_tready,
  input  logic [AXIS_DATA_WIDTH-1:0]      from_local_tdata,
  input  logic [AXIS_KEEP_WIDTH-1:0]      from_local_tkeep,
  input  logic [AXIS_KIP_TUSER_WIDTH-1:0] from_local_tuser,
  input  logic                            from_local_tlast,

  input  logic                            from_gs_tvalid,
  output logic                            from_gs_tready,
  input  logic [AXIS_DATA_WIDTH-1:0]      from_gs_tdata,
  input  logic [AXIS_KEEP_WIDTH-1:0]      from_gs_tkeep,
  input  logic [AXIS_KIP_TUSER_WIDTH-1:0] from_gs_tuser,
  input  logic                            from_gs_tlast,

  output logic                            to_kernels_tvalid,
  input  logic                            to_kernels_tready,
  output logic [AXIS_DATA_WIDTH-1:0]      to_kernels_tdata,
  output logic [AXIS_KEEP_WIDTH-1:0]      to_kernels_tkeep,
  output logic [AXIS_KIP_TUSER_WIDTH-1:0] to_kernels_tuser,
  output logic                            to_kernels_tlast,

  output logic [COUNT_WIDTH-1:0]          o_local_pkt_count,
  output logic [COUNT_WIDTH-1:0]          o_remote_pkt_count
);

  localparam int unsigned BeatW =
      AXIS_DATA_WIDTH + AXIS_KEEP_WIDTH + AXIS_KIP_TUSER_WIDTH + 1;

  // tuser must be wide enough to carry the IP address field.
  if (IP_ADDRESS_WIDTH > AXIS_KIP_TUSER_WIDTH) begin : g_tuser_too_narrow
    $error("AXIS_KIP_TUSER_WIDTH must be at least IP_ADDRESS_WIDTH");
  end

  typedef enum logic [1:0] {StIdle, StLocal, StRemote} state_e;

  state_e                 state_q, state_d;
  logic                   last_grant_q, last_grant_d;  // 0 = local, 1 = remote
  logic                   skid_ready_q, skid_ready_d;
  logic [BeatW-1:0]       mem_q [2];
  logic [BeatW-1:0]       mem_d [2];
  logic                   wr_ptr_q, wr_ptr_d;
  logic                   rd_ptr_q, rd_ptr_d;
  logic [1:0]             cnt_q, cnt_d;
  logic [COUNT_WIDTH-1:0] local_cnt_q, local_cnt_d;
  logic [COUNT_WIDTH-1:0] remote_cnt_q, remote_cnt_d;

  logic             grant_local, grant_remote;
  logic             local_acc, remote_acc, push, pop;
  logic [BeatW-1:0] in_beat;

  always_comb begin
    grant_local  = 1'b0;
    grant_remote = 1'b0;
    unique case (state_q)
      StLocal:  grant_local  = 1'b1;
      StRemote: grant_remote = 1'b1;
      default: begin
        if (from_local_tvalid && from_gs_tvalid) begin
          grant_local  = last_grant_q;
          grant_remote = !last_grant_q;
        end else begin
          grant_local  = from_local_tvalid;
          grant_remote = from_gs_tvalid;
        end
      end
    endcase
  end

  assign from_local_tready = grant_local && skid_ready_q;
  assign from_gs_tready    = grant_remote && skid_ready_q;

  assign local_acc  = from_local_tvalid && from_local_tready;
  assign remote_acc = from_gs_tvalid && from_gs_tready;
  assign push       = local_acc || remote_acc;
  assign in_beat    = local_acc
      ? {from_local_tdata, from_local_tkeep, from_local_tuser, from_local_tlast}
      : {from_gs_tdata, from_gs_tkeep, from_gs_tuser, from_gs_tlast};

  assign to_kernels_tvalid = (cnt_q != 2'd0);
  assign pop               = to_kernels_tvalid && to_kernels_tready;
  assign {to_kernels_tdata, to_kernels_tkeep, to_kernels_tuser, to_kernels_tlast} =
      mem_q[rd_ptr_q];

  assign o_local_pkt_count  = local_cnt_q;
  assign o_remote_pkt_count = remote_cnt_q;

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    if (local_acc) begin
      last_grant_d = 1'b0;
      state_d      = from_local_tlast ? StIdle : StLocal;
    end else if (remote_acc) begin
      last_grant_d = 1'b1;
      state_d      = from_gs_tlast ? StIdle : StRemote;
    end

    mem_d = mem_q;
    if (push) mem_d[wr_ptr_q] = in_beat;
    wr_ptr_d     = wr_ptr_q ^ push;
    rd_ptr_d     = rd_ptr_q ^ pop;
    cnt_d        = cnt_q + {1'b0, push} - {1'b0, pop};
    skid_ready_d = (cnt_d < 2'd2);

    local_cnt_d  = local_cnt_q + {{(COUNT_WIDTH-1){1'b0}}, local_acc && from_local_tlast};
    remote_cnt_d = remote_cnt_q + {{(COUNT_WIDTH-1){1'b0}}, remote_acc && from_gs_tlast};
  end

  // skid_ready_q resets low so neither source is ready while reset is asserted.
  always_ff @(posedge i_clk or negedge i_ap_rst_n) begin
    if (!i_ap_rst_n) begin
      state_q      <= StIdle;
      last_grant_q <= 1'b1;
      skid_ready_q <= 1'b0;
      mem_q[0]     <= '0;
      mem_q[1]     <= '0;
      wr_ptr_q     <= 1'b0;
      rd_ptr_q     <= 1'b0;
      cnt_q        <= 2'd0;
      local_cnt_q  <= '0;
      remote_cnt_q <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      skid_ready_q <= skid_ready_d;
      mem_q        <= mem_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      cnt_q        <= cnt_d;
      local_cnt_q  <= local_cnt_d;
      remote_cnt_q <= remote_cnt_d;
    end
  end

endmodule

// File: tb/tb_kip_rx_merger.sv
// Directed bench for kip_rx_merger: source drivers fed from queues, expected beats in a
// scoreboard queue built in predicted arbitration order, compared as the sink accepts them.
module tb_kip_rx_merger;

  localparam int unsigned DW = 64;
  localparam int unsigned KW = 8;
  localparam int unsigned UW = 32;
  localparam int unsigned CW = 4;

  typedef struct packed {
    logic [DW-1:0] data;
    logic [KW-1:0] keep;
    logic [UW-1:0] user;
    logic          last;
  } beat_t;

  logic          i_clk = 1'b0;
  logic          i_ap_rst_n;
  logic          from_local_tvalid, from_local_tready, from_local_tlast;
  logic [DW-1:0] from_local_tdata;
  logic [KW-1:0] from_local_tkeep;
  logic [UW-1:0] from_local_tuser;
  logic          from_gs_tvalid, from_gs_tready, from_gs_tlast;
  logic [DW-1:0] from_gs_tdata;
  logic [KW-1:0] from_gs_tkeep;
  logic [UW-1:0] from_gs_tuser;
  logic          to_kernels_tvalid, to_kernels_tready, to_kernels_tlast;
  logic [DW-1:0] to_kernels_tdata;
  logic [KW-1:0] to_kernels_tkeep;
  logic [UW-1:0] to_kernels_tuser;
  logic [CW-1:0] o_local_pkt_count, o_remote_pkt_count;

  kip_rx_merger #(
    .AXIS_DATA_WIDTH      (DW),
    .AXIS_KEEP_WIDTH      (KW),
    .AXIS_KIP_TUSER_WIDTH (UW),
    .IP_ADDRESS_WIDTH     (32),
    .COUNT_WIDTH          (CW)
  ) dut (
    .i_clk              (i_clk),
    .i_ap_rst_n         (i_ap_rst_n),
    .from_local_tvalid  (from_local_tvalid),
    .from_local_tready  (from_local_tready),
    .from_local_tdata   (from_local_tdata),
    .from_local_tkeep   (from_local_tkeep),
    .from_local_tuser   (from_local_tuser),
    .from_local_tlast   (from_local_tlast),
    .from_gs_tvalid     (from_gs_tvalid),
    .from_gs_tready     (from_gs_tready),
    .from_gs_tdata      (from_gs_tdata),
    .from_gs_tkeep      (from_gs_tkeep),
    .from_gs_tuser      (from_gs_tuser),
    .from_gs_tlast      (from_gs_tlast),
    .to_kernels_tvalid  (to_kernels_tvalid),
    .to_kernels_tready  (to_kernels_tready),
    .to_kernels_tdata   (to_kernels_tdata),
    .to_kernels_tkeep   (to_kernels_tkeep),
    .to_kernels_tuser   (to_kernels_tuser),
    .to_kernels_tlast   (to_kernels_tlast),
    .o_local_pkt_count  (o_local_pkt_count),
    .o_remote_pkt_count (o_remote_pkt_count)
  );

  always #5 i_clk = ~i_clk;

  beat_t    lq[$], gq[$], exp_q[$];
  int       acc_q[$];
  int       checks = 0, failures = 0;
  int       cyc = 0, l_acc = 0, stall_seen = 0;
  int       out_first = -1, out_last = -1;
  bit       lat_chk = 1'b1, mon_off = 1'b0, sink_mode = 1'b0;
  logic [CW-1:0] exp_lcnt = '0, exp_rcnt = '0;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic gen(input bit src, input int len, input logic [UW-1:0] user,
                     input bit rnd_keep, input bit to_exp);
    beat_t b;
    for (int i = 0; i < len; i++) begin
      b.data = {$urandom, $urandom};
      b.keep = rnd_keep ? KW'($urandom) : '1;
      b.user = user;
      b.last = (i == len - 1);
      if (src) gq.push_back(b);
      else lq.push_back(b);
      if (to_exp) exp_q.push_back(b);
    end
    if (to_exp) begin
      if (src) exp_rcnt++;
      else exp_lcnt++;
    end
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while (exp_q.size() != 0 && n < 500) begin
      @(negedge i_clk);
      n++;
    end
    repeat (3) @(negedge i_clk);
    check({tag, "_drained"}, exp_q.size(), 0);
  endtask

  task automatic check_counts(input string tag);
    check({tag, "_local_cnt"}, o_local_pkt_count, exp_lcnt);
    check({tag, "_remote_cnt"}, o_remote_pkt_count, exp_rcnt);
  endtask

  initial forever begin
    @(posedge i_clk);
    cyc++;
  end

  initial begin : drv_local
    bit fire;
    from_local_tvalid = 1'b0;
    {from_local_tdata, from_local_tkeep, from_local_tuser, from_local_tlast} = '0;
    forever begin
      @(negedge i_clk);
      fire = from_local_tvalid && from_local_tready;
      if (fire) begin
        acc_q.push_back(cyc);
        l_acc++;
      end
      @(posedge i_clk);
      #1;
      if (!i_ap_rst_n) lq.delete();
      else if (fire) lq.delete(0);
      from_local_tvalid = (lq.size() > 0);
      if (lq.size() > 0)
        {from_local_tdata, from_local_tkeep, from_local_tuser, from_local_tlast} = lq[0];
    end
  end

  initial begin : drv_gs
    bit fire;
    from_gs_tvalid = 1'b0;
    {from_gs_tdata, from_gs_tkeep, from_gs_tuser, from_gs_tlast} = '0;
    forever begin
      @(negedge i_clk);
      fire = from_gs_tvalid && from_gs_tready;
      if (fire) acc_q.push_back(cyc);
      @(posedge i_clk);
      #1;
      if (!i_ap_rst_n) gq.delete();
      else if (fire) gq.delete(0);
      from_gs_tvalid = (gq.size() > 0);
      if (gq.size() > 0)
        {from_gs_tdata, from_gs_tkeep, from_gs_tuser, from_gs_tlast} = gq[0];
    end
  end

  // Sink pattern 1,0,0,1 when sink_mode is set, otherwise always ready.
  initial begin : drv_sink
    int ph = 0;
    to_kernels_tready = 1'b1;
    forever begin
      @(posedge i_clk);
      #1;
      if (sink_mode) begin
        to_kernels_tready = (ph == 0 || ph == 3);
        ph = (ph + 1) % 4;
      end else begin
        to_kernels_tready = 1'b1;
      end
    end
  end

  initial begin : mon
    beat_t ob, snap;
    bit    stalled = 1'b0;
    int    st;
    forever begin
      @(negedge i_clk);
      ob = {to_kernels_tdata, to_kernels_tkeep, to_kernels_tuser, to_kernels_tlast};
      if (!i_ap_rst_n || mon_off) begin
        stalled = 1'b0;
      end else begin
        if (stalled) begin
          check("hold_valid", to_kernels_tvalid, 1'b1);
          check("hold_data", ob, snap);
        end
        if (to_kernels_tvalid && to_kernels_tready) begin
          check("beat_expected", exp_q.size() > 0, 1'b1);
          if (exp_q.size() > 0) check("beat", ob, exp_q.pop_front());
          st = (acc_q.size() > 0) ? acc_q.pop_front() : -100;
          if (lat_chk) check("latency", cyc - st, 1);
          if (out_first < 0) out_first = cyc;
          out_last = cyc;
        end
        if (sink_mode && (from_local_tvalid || from_gs_tvalid) &&
            !from_local_tready && !from_gs_tready)
          stall_seen++;
        stalled = to_kernels_tvalid && !to_kernels_tready;
        snap    = ob;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin : main
    int n, base;
    i_ap_rst_n = 1'b0;
    #12;
    check("rst_tvalid", to_kernels_tvalid, 1'b0);
    check("rst_tdata", to_kernels_tdata, '0);
    check("rst_tkeep", to_kernels_tkeep, '0);
    check("rst_tuser", to_kernels_tuser, '0);
    check("rst_tlast", to_kernels_tlast, 1'b0);
    check("rst_local_tready", from_local_tready, 1'b0);
    check("rst_gs_tready", from_gs_tready, 1'b0);
    check_counts("rst");
    repeat (3) @(negedge i_clk);
    i_ap_rst_n = 1'b1;
    @(negedge i_clk);

    // Single local 3-beat packet.
    gen(1'b0, 3, 32'h0A00_0001, 1'b0, 1'b1);
    drain("t1");
    check_counts("t1");

    // One remote beat so the following tie favours local.
    gen(1'b1, 1, 32'h0B00_0001, 1'b0, 1'b1);
    drain("t2pre");

    // Both sources offering back-to-back 2-beat packets: L,L,R,R,...
    out_first = -1;
    for (int p = 0; p < 4; p++) begin
      gen(1'b0, 2, 32'h0A00_0002, 1'b0, 1'b1);
      gen(1'b1, 2, 32'h0B00_0002, 1'b0, 1'b1);
    end
    drain("t2");
    check("t2_no_bubble", out_last - out_first, 15);
    check_counts("t2");

    // Remote 4-beat packet; local arrives mid-packet and must wait.
    gen(1'b1, 4, 32'h0B00_0003, 1'b0, 1'b1);
    repeat (2) @(negedge i_clk);
    gen(1'b0, 2, 32'h0A00_0003, 1'b0, 1'b1);
    n = 0;
    while (gq.size() > 0 && n < 50) begin
      @(negedge i_clk);
      if (gq.size() > 0) check("t3_local_blocked", from_local_tready, 1'b0);
      n++;
    end
    drain("t3");
    check_counts("t3");

    // Random packets on both sources under 1,0,0,1 sink backpressure; remote wins first tie.
    lat_chk = 1'b0;
    sink_mode = 1'b1;
    stall_seen = 0;
    for (int p = 0; p < 6; p++) begin
      gen(1'b1, 1 + int'($urandom_range(3)), $urandom, 1'b1, 1'b1);
      gen(1'b0, 1 + int'($urandom_range(3)), $urandom, 1'b1, 1'b1);
    end
    drain("t4");
    check("t4_skid_full_stall", stall_seen > 0, 1'b1);
    check("t4_sources_empty", lq.size() + gq.size(), 0);
    check_counts("t4");
    sink_mode = 1'b0;
    repeat (4) @(negedge i_clk);
    lat_chk = 1'b1;

    // Reset during beat 2 of a 5-beat local packet.
    mon_off = 1'b1;
    base = l_acc;
    gen(1'b0, 5, 32'h0A00_0005, 1'b0, 1'b0);
    n = 0;
    while (l_acc < base + 2 && n < 100) begin
      @(negedge i_clk);
      n++;
    end
    check("t5_reached_beat2", l_acc >= base + 2, 1'b1);
    @(posedge i_clk);
    #2;
    i_ap_rst_n = 1'b0;
    #1;
    check("t5_rst_tvalid", to_kernels_tvalid, 1'b0);
    check("t5_rst_local_tready", from_local_tready, 1'b0);
    exp_q.delete();
    acc_q.delete();
    exp_lcnt = '0;
    exp_rcnt = '0;
    check_counts("t5_rst");
    repeat (3) @(negedge i_clk);
    i_ap_rst_n = 1'b1;
    mon_off = 1'b0;
    @(negedge i_clk);
    gen(1'b0, 1, 32'h0A00_0006, 1'b0, 1'b1);
    gen(1'b1, 1, 32'h0B00_0006, 1'b0, 1'b1);
    drain("t5");
    check_counts("t5");

    // Counter wrap at COUNT_WIDTH=4: 17 local packets after a fresh reset.
    @(posedge i_clk);
    #2;
    i_ap_rst_n = 1'b0;
    exp_q.delete();
    acc_q.delete();
    exp_lcnt = '0;
    exp_rcnt = '0;
    repeat (2) @(negedge i_clk);
    i_ap_rst_n = 1'b1;
    @(negedge i_clk);
    for (int p = 0; p < 17; p++) gen(1'b0, 1, 32'h0A00_0007, 1'b0, 1'b1);
    drain("t6");
    check("t6_local_wrap", o_local_pkt_count, 4'd1);
    check_counts("t6");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
